// File: rtl/rstgen_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rstgen_sequencer_pkg
// Shared types and helpers for the reset sequencing controller.
//   state_e   : sequencer FSM states (HOLD, STEP, PULSE, RUN)
//   cnt_width : width of the spacing counter, sized for the longest interval
// ---------------------------------------------------------------------------
package rstgen_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STEP  = 2'd1,
    PULSE = 2'd2,
    RUN   = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned step_cycles,
                                            input int unsigned pulse_cycles);
    int unsigned m;
    m = hold_cycles;
    if (step_cycles > m) m = step_cycles;
    if (pulse_cycles > m) m = pulse_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lzc.sv
// ---------------------------------------------------------------------------
// lzc
// Leading/trailing zero counter.
//   in_i    : input vector
//   cnt_o   : MODE=0 -> index of lowest set bit (trailing zeros)
//             MODE=1 -> number of leading zeros
//   empty_o : high when in_i is all zero (cnt_o is then 0)
// ---------------------------------------------------------------------------
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o = '0;
    if (!MODE) begin
      // Scan from the top so the lowest set bit is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      // Scan from the bottom so the highest set bit is the last one written.
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/tc_clk_mux2.sv
// ---------------------------------------------------------------------------
// tc_clk_mux2
// Technology clock/reset mux cell (behavioural model).
//   clk0_i    : selected when clk_sel_i = 0
//   clk1_i    : selected when clk_sel_i = 1
//   clk_sel_i : select
//   clk_o     : muxed output
// ---------------------------------------------------------------------------
module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);

  assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/rstgen_sequencer.sv
// ---------------------------------------------------------------------------
// rstgen_sequencer
// Releases NumDomains reset domains one at a time in ascending order after
// rst_ni deasserts, then serves software reset requests that pulse a chosen
// subset of domains and re-release them in order. Test mode hands every
// domain reset straight to rst_ni.
//   clk_i       : clock
//   rst_ni      : async active-low reset (already synchronized)
//   test_mode_i : DFT bypass select
//   req_valid_i : software reset request valid
//   req_mask_i  : domains to reset, bit i = domain i
//   req_ready_o : request accept (0 in test mode)
//   rst_no      : per-domain active-low resets, flop-driven outside test mode
//   done_o      : all domains released and sequencer idle
// ---------------------------------------------------------------------------
module rstgen_sequencer
  import rstgen_sequencer_pkg::*;
#(
  parameter int unsigned NumDomains  = 4,
  parameter int unsigned HoldCycles  = 16,
  parameter int unsigned StepCycles  = 8,
  parameter int unsigned PulseCycles = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  input  logic                  req_valid_i,
  input  logic [NumDomains-1:0] req_mask_i,
  output logic                  req_ready_o,
  output logic [NumDomains-1:0] rst_no,
  output logic                  done_o
);

  localparam int unsigned CntW = cnt_width(HoldCycles, StepCycles, PulseCycles);
  localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StepLast  = CntW'(StepCycles - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(PulseCycles - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NumDomains-1:0] rst_q, rst_d;
  // Domains still waiting for release; the lowest one goes next.
  logic [NumDomains-1:0] pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic [CntW-1:0]       limit;
  logic [IdxW-1:0]       low_idx;
  logic                  pend_empty;
  logic                  handshake;

  lzc #(
    .WIDTH     (NumDomains),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxW)
  ) i_lzc (
    .in_i    (pend_q),
    .cnt_o   (low_idx),
    .empty_o (pend_empty)
  );

  assign req_ready_o = ready_q & ~test_mode_i;
  assign done_o      = done_q;
  assign handshake   = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    pend_d  = pend_q;
    ready_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      STEP:    limit = StepLast;
      PULSE:   limit = PulseLast;
      default: limit = HoldLast;
    endcase

    if (state_q == RUN) begin
      ready_d = 1'b1;
      done_d  = 1'b1;
      // A zero mask is accepted but changes nothing.
      if (handshake && (|req_mask_i)) begin
        rst_d   = rst_q & ~req_mask_i;
        pend_d  = req_mask_i;
        cnt_d   = '0;
        state_d = PULSE;
        ready_d = 1'b0;
        done_d  = 1'b0;
      end
    end else if ((cnt_q == limit) && !pend_empty) begin
      // HOLD, STEP and PULSE all end by releasing the lowest pending domain.
      for (int unsigned i = 0; i < NumDomains; i++) begin
        if (low_idx == IdxW'(i)) begin
          rst_d[i]  = 1'b1;
          pend_d[i] = 1'b0;
        end
      end
      cnt_d = '0;
      if (pend_d == '0) begin
        state_d = RUN;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end else begin
        state_d = STEP;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '0;
      pend_q  <= '1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Bypass mux per domain: in test mode DFT drives every domain via rst_ni.
  for (genvar g = 0; g < NumDomains; g++) begin : gen_bypass
    tc_clk_mux2 i_rst_mux (
      .clk0_i    (rst_q[g]),
      .clk1_i    (rst_ni),
      .clk_sel_i (test_mode_i),
      .clk_o     (rst_no[g])
    );
  end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  initial begin
    if (NumDomains < 1)  $fatal(1, "rstgen_sequencer: NumDomains must be >= 1");
    if (HoldCycles < 1)  $fatal(1, "rstgen_sequencer: HoldCycles must be >= 1");
    if (StepCycles < 1)  $fatal(1, "rstgen_sequencer: StepCycles must be >= 1");
    if (PulseCycles < 1) $fatal(1, "rstgen_sequencer: PulseCycles must be >= 1");
  end
`endif
`endif

endmodule

// File: tb/tb_rstgen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rstgen_sequencer
// Directed bench for rstgen_sequencer: a default-parameter instance driven
// by a table of per-edge vectors plus hand-written corner sequences, and a
// NumDomains=1 / all-cycles=1 instance for the minimal corner.
// Edge numbering: edge 0 is the clock edge just before rst_ni deasserts;
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_rstgen_sequencer;

  logic       clk;
  logic       rst_n, tm, valid;
  logic [3:0] mask;
  logic       ready, done;
  logic [3:0] rst_no;

  logic       rst1_n, tm1, valid1;
  logic [0:0] mask1;
  logic       ready1, done1;
  logic [0:0] rst1_no;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  typedef struct {
    int         e;
    logic [3:0] exp_rst;
    logic       exp_done;
    logic       exp_ready;
    logic       valid;
    logic [3:0] mask;
  } vec_t;

  vec_t vec[15];

  rstgen_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (tm),
    .req_valid_i (valid),
    .req_mask_i  (mask),
    .req_ready_o (ready),
    .rst_no      (rst_no),
    .done_o      (done)
  );

  rstgen_sequencer #(
    .NumDomains  (1),
    .HoldCycles  (1),
    .StepCycles  (1),
    .PulseCycles (1)
  ) dut1 (
    .clk_i       (clk),
    .rst_ni      (rst1_n),
    .test_mode_i (tm1),
    .req_valid_i (valid1),
    .req_mask_i  (mask1),
    .req_ready_o (ready1),
    .rst_no      (rst1_no),
    .done_o      (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go(input int e);
    while (edge_n < e) step();
  endtask

  // Deassert rst_ni just after a rising edge; that edge becomes edge 0.
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    rst_n = 1'b0; tm = 1'b0; valid = 1'b0; mask = '0;
    rst1_n = 1'b0; tm1 = 1'b0; valid1 = 1'b0; mask1 = '0;

    //          edge  rst_no   done  ready valid mask (inputs applied after check)
    vec[0]  = '{15, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vec[1]  = '{16, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000};
    vec[2]  = '{20, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001};
    vec[3]  = '{23, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001};
    vec[4]  = '{24, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b0001};
    vec[5]  = '{31, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b0001};
    vec[6]  = '{32, 4'b0111, 1'b0, 1'b0, 1'b1, 4'b0001};
    vec[7]  = '{39, 4'b0111, 1'b0, 1'b0, 1'b1, 4'b0001};
    vec[8]  = '{40, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001};
    vec[9]  = '{41, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000};
    vec[10] = '{44, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000};
    vec[11] = '{45, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000};
    vec[12] = '{50, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000};
    vec[13] = '{51, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000};
    vec[14] = '{52, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst_no", 32'(rst_no), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_done", 32'(done), 32'h0);

    // Power-on sequence, back-pressured request, zero-mask request
    release_rst();
    for (int i = 0; i < 15; i++) begin
      go(vec[i].e);
      chk("tbl_rst_no", 32'(rst_no), 32'(vec[i].exp_rst));
      chk("tbl_done", 32'(done), 32'(vec[i].exp_done));
      chk("tbl_ready", 32'(ready), 32'(vec[i].exp_ready));
      valid = vec[i].valid;
      mask  = vec[i].mask;
    end

    // Partial software reset accepted on edge 100
    go(99);
    valid = 1'b1;
    mask  = 4'b1010;
    go(100);
    chk("sw_accept_rst_no", 32'(rst_no), 32'h5);
    chk("sw_accept_done", 32'(done), 32'h0);
    chk("sw_accept_ready", 32'(ready), 32'h0);
    valid = 1'b0;
    mask  = '0;
    for (int e = 101; e < 112; e++) begin
      go(e);
      chk("sw_untouched", 32'({rst_no[2], rst_no[0]}), 32'h3);
      chk("sw_busy_done", 32'(done), 32'h0);
      if (e == 103) chk("sw_pulse_hold", 32'(rst_no), 32'h5);
      if (e == 104) chk("sw_rel_d1", 32'(rst_no), 32'h7);
      if (e == 111) chk("sw_before_d3", 32'(rst_no), 32'h7);
    end
    go(112);
    chk("sw_rel_d3", 32'(rst_no), 32'hF);
    chk("sw_done", 32'(done), 32'h1);
    chk("sw_ready", 32'(ready), 32'h1);

    // Reset asserted mid-sequence
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();
    go(29);
    chk("mid_before", 32'(rst_no), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_rst_no", 32'(rst_no), 32'h0);
    chk("mid_async_done", 32'(done), 32'h0);
    chk("mid_async_ready", 32'(ready), 32'h0);
    repeat (2) @(posedge clk);
    release_rst();
    go(15);
    chk("restart_hold", 32'(rst_no), 32'h0);
    go(16);
    chk("restart_d0", 32'(rst_no), 32'h1);
    go(24);
    chk("restart_d1", 32'(rst_no), 32'h3);

    // Test mode bypass
    tm = 1'b1;
    #1;
    chk("tm_follow_hi", 32'(rst_no), 32'hF);
    valid = 1'b1;
    mask  = 4'b1111;
    #1;
    chk("tm_ready_step", 32'(ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("tm_follow_lo", 32'(rst_no), 32'h0);
    chk("tm_ready_rst", 32'(ready), 32'h0);
    release_rst();
    #1;
    chk("tm_follow_rel", 32'(rst_no), 32'hF);
    go(40);
    chk("tm_done", 32'(done), 32'h1);
    chk("tm_ready_run", 32'(ready), 32'h0);
    go(42);
    chk("tm_no_accept_done", 32'(done), 32'h1);
    valid = 1'b0;
    mask  = '0;
    #1;
    tm = 1'b0;
    #1;
    chk("tm_exit_rst_no", 32'(rst_no), 32'hF);
    chk("tm_exit_ready", 32'(ready), 32'h1);

    // Minimal corner: one domain, all intervals 1
    chk("c1_reset_rst", 32'(rst1_no), 32'h0);
    chk("c1_reset_done", 32'(done1), 32'h0);
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    #1;
    chk("c1_pre_release", 32'(rst1_no), 32'h0);
    @(posedge clk);
    #1;
    chk("c1_release", 32'(rst1_no), 32'h1);
    chk("c1_done", 32'(done1), 32'h1);
    chk("c1_ready", 32'(ready1), 32'h1);
    valid1 = 1'b1;
    mask1  = 1'b1;
    @(posedge clk);
    #1;
    chk("c1_pulse_lo", 32'(rst1_no), 32'h0);
    chk("c1_pulse_done", 32'(done1), 32'h0);
    chk("c1_pulse_ready", 32'(ready1), 32'h0);
    valid1 = 1'b0;
    mask1  = 1'b0;
    @(posedge clk);
    #1;
    chk("c1_pulse_hi", 32'(rst1_no), 32'h1);
    chk("c1_done_again", 32'(done1), 32'h1);
    @(posedge clk);
    #1;
    chk("c1_stays_hi", 32'(rst1_no), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
